// File: rtl/jtag_ocimem_pkg.sv
// Shared types and default widths for the JTAG / CPU debug-RAM arbiter.
package jtag_ocimem_pkg;

    localparam int RAM_AW_DEFAULT = 8;
    localparam int DW_DEFAULT     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_JTAG,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/jtag_ocimem_arbiter_rr_arb.sv
// Two-way round-robin pick: on a tie the side that did not own the last access wins.
module jtag_ocimem_rr_arb
    import jtag_ocimem_pkg::*;
(
    input  logic   jtag_req,
    input  logic   cpu_req,
    input  owner_t last_owner,
    output owner_t grant
);

    always_comb begin
        grant = OWN_JTAG;
        if (jtag_req && cpu_req) begin
            grant = (last_owner == OWN_JTAG) ? OWN_CPU : OWN_JTAG;
        end else if (cpu_req) begin
            grant = OWN_CPU;
        end
    end

endmodule

// File: rtl/jtag_ocimem_arbiter.sv
// Shares one single-port debug RAM between the JTAG monitor and the CPU bus.
//   state      | meaning
//   ST_IDLE    | arbitrate, latch owner/op/address/data
//   ST_ISSUE   | drive RAM command for one cycle
//   ST_CAPTURE | register RAM read data (reads only)
//   ST_DONE    | ack JTAG or release CPU stall
module jtag_ocimem_arbiter
    import jtag_ocimem_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT,
    parameter int DW     = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic              jtag_ld_addr,
    input  logic [RAM_AW-1:0] jtag_addr,
    input  logic [DW-1:0]     jtag_wdata,
    output logic              jtag_ack,
    output logic [DW-1:0]     mon_dreg,
    output logic              monitor_ready,
    input  logic [RAM_AW-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DW-1:0]     cpu_writedata,
    output logic [DW-1:0]     cpu_readdata,
    output logic              cpu_waitrequest,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    state_t            state, state_nx;
    owner_t            owner, last_owner, grant;
    logic              op_wr;
    logic [RAM_AW-1:0] addr_q, ptr, used_addr;
    logic [DW-1:0]     wdata_q;
    logic              cpu_req, any_req;

    assign cpu_req   = cpu_read | cpu_write;
    assign any_req   = jtag_req | cpu_req;
    assign used_addr = jtag_ld_addr ? jtag_addr : ptr;

    jtag_ocimem_rr_arb u_rr_arb (
        .jtag_req   (jtag_req),
        .cpu_req    (cpu_req),
        .last_owner (last_owner),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (any_req) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = op_wr ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_DONE;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= OWN_CPU;
            last_owner   <= OWN_CPU;
            op_wr        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ptr          <= '0;
            mon_dreg     <= '0;
            cpu_readdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= grant;
                        last_owner <= grant;
                        if (grant == OWN_JTAG) begin
                            op_wr   <= jtag_wr;
                            addr_q  <= used_addr;
                            wdata_q <= jtag_wdata;
                        end else begin
                            op_wr   <= cpu_write;
                            addr_q  <= cpu_address;
                            wdata_q <= cpu_writedata;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (owner == OWN_JTAG) mon_dreg <= ram_rdata;
                    else                   cpu_readdata <= ram_rdata;
                end
                // Pointer only advances on completion, so an aborted access leaves it alone.
                ST_DONE: begin
                    if (owner == OWN_JTAG) ptr <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ram_en          = (state == ST_ISSUE);
    assign ram_we          = (state == ST_ISSUE) && op_wr;
    assign ram_addr        = addr_q;
    assign ram_wdata       = wdata_q;
    assign jtag_ack        = (state == ST_DONE) && (owner == OWN_JTAG);
    assign cpu_waitrequest = cpu_req && !((state == ST_DONE) && (owner == OWN_CPU));
    assign monitor_ready   = !(((state == ST_IDLE) && any_req && (grant == OWN_JTAG)) ||
                               (((state == ST_ISSUE) || (state == ST_CAPTURE)) &&
                                (owner == OWN_JTAG)));

endmodule
